// File: rtl/fir_pkg.sv
// Constants and types shared by the 3-tap FIR (taps 1, 2, 3) and its inverse decoder.
package fir_pkg;
  localparam int C0   = 1;
  localparam int C1   = 2;
  localparam int C2   = 3;
  localparam int XW   = 4;
  localparam int YW   = 8;
  localparam int CNTW = 16;

  typedef enum logic {RUN, FAULT} state_t;
endpackage

// File: rtl/fir_inv_dp.sv
// Combinational deconvolution step: d = y - C1*h1 - C2*h2, with a range check
// and a value clamped to the sample range.
module fir_inv_dp #(
  parameter int XW = 4,
  parameter int YW = 8,
  parameter int C1 = 2,
  parameter int C2 = 3
) (
  input  logic [YW-1:0] y,
  input  logic [XW-1:0] h1,
  input  logic [XW-1:0] h2,
  output logic          good,
  output logic [XW-1:0] sat
);
  // Three extra bits keep the signed difference exact for any y and history.
  localparam int DW = YW + 3;
  localparam logic signed [DW-1:0] XMAX = DW'((1 << XW) - 1);

  logic signed [DW-1:0] y_s, p1, p2, d;

  always_comb begin
    y_s  = $signed({{(DW-YW){1'b0}}, y});
    p1   = $signed(DW'(C1)) * $signed({{(DW-XW){1'b0}}, h1});
    p2   = $signed(DW'(C2)) * $signed({{(DW-XW){1'b0}}, h2});
    d    = y_s - p1 - p2;
    good = !d[DW-1] && (d <= XMAX);
    if (d[DW-1])
      sat = '0;
    else if (good)
      sat = d[XW-1:0];
    else
      sat = '1;
  end
endmodule

// File: rtl/fir_inv_decoder.sv
// Inverse FIR decoder: recovers 4-bit samples from the 3-tap FIR output,
// flagging impossible sequences and holding FAULT until sync_clr or rst.
module fir_inv_decoder
  import fir_pkg::*;
#(
  parameter int XW   = fir_pkg::XW,
  parameter int YW   = fir_pkg::YW,
  parameter int C1   = fir_pkg::C1,
  parameter int C2   = fir_pkg::C2,
  parameter int CNTW = fir_pkg::CNTW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [YW-1:0]   y_in,
  input  logic            sync_clr,
  output logic [XW-1:0]   x_out,
  output logic            out_valid,
  output logic            err,
  output logic [CNTW-1:0] sample_cnt
);
  state_t          state_reg, state_next;
  logic [XW-1:0]   h1_reg, h1_next, h2_reg, h2_next;
  logic [XW-1:0]   x_reg, x_next;
  logic            ov_reg, ov_next;
  logic            err_reg, err_next;
  logic [CNTW-1:0] cnt_reg, cnt_next;
  logic            good;
  logic [XW-1:0]   sat;

  // History is zero throughout FAULT, so FAULT decodes against a cleared history.
  fir_inv_dp #(.XW(XW), .YW(YW), .C1(C1), .C2(C2)) u_dp (
    .y    (y_in),
    .h1   (h1_reg),
    .h2   (h2_reg),
    .good (good),
    .sat  (sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= RUN;
      h1_reg    <= '0;
      h2_reg    <= '0;
      x_reg     <= '0;
      ov_reg    <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      h1_reg    <= h1_next;
      h2_reg    <= h2_next;
      x_reg     <= x_next;
      ov_reg    <= ov_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    h1_next    = h1_reg;
    h2_next    = h2_reg;
    x_next     = x_reg;
    ov_next    = 1'b0;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    // sync_clr beats a coincident strobe: the sample is dropped.
    if (sync_clr) begin
      state_next = RUN;
      h1_next    = '0;
      h2_next    = '0;
      err_next   = 1'b0;
      cnt_next   = '0;
    end else if (in_valid) begin
      x_next  = sat;
      ov_next = 1'b1;
      if (state_reg == RUN) begin
        if (good) begin
          h2_next  = h1_reg;
          h1_next  = sat;
          cnt_next = cnt_reg + 1'b1;
        end else begin
          h1_next    = '0;
          h2_next    = '0;
          err_next   = 1'b1;
          state_next = FAULT;
        end
      end
    end
  end

  assign x_out      = x_reg;
  assign out_valid  = ov_reg;
  assign err        = err_reg;
  assign sample_cnt = cnt_reg;
endmodule

// File: tb/tb_fir_inv_decoder.sv
// Self-checking bench for fir_inv_decoder: directed table, hand sequences,
// randomized run against a reference model, and counter wrap.
module tb_fir_inv_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  y_in = '0;
  logic        sync_clr = 1'b0;
  logic [3:0]  x_out;
  logic        out_valid;
  logic        err;
  logic [15:0] sample_cnt;

  int checks = 0;
  int errors = 0;

  fir_inv_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .y_in       (y_in),
    .sync_clr   (sync_clr),
    .x_out      (x_out),
    .out_valid  (out_valid),
    .err        (err),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit sclr;
    bit iv;
    int y;
    int ex;
    int eov;
    int eerr;
    int ecnt;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int ex, input int eov, input int eerr, input int ecnt);
    check({tag, " x_out"}, 32'(x_out), 32'(ex));
    check({tag, " out_valid"}, 32'(out_valid), 32'(eov));
    check({tag, " err"}, 32'(err), 32'(eerr));
    check({tag, " sample_cnt"}, 32'(sample_cnt), 32'(ecnt));
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the edge.
  task automatic step(input bit sclr, input bit iv, input int y);
    sync_clr = sclr;
    in_valid = iv;
    y_in     = 8'(y);
    @(posedge clk);
    #1;
    sync_clr = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #2 rst = 1'b0;
  endtask

  // Reference model state: last two recovered samples, fault flag, count, last output.
  int m_h1, m_h2, m_cnt, m_x;
  bit m_fault, m_ov;

  task automatic model_reset();
    m_h1 = 0; m_h2 = 0; m_cnt = 0; m_x = 0; m_fault = 0; m_ov = 0;
  endtask

  task automatic model_step(input bit sclr, input bit iv, input int y);
    int d;
    m_ov = 0;
    if (sclr) begin
      m_h1 = 0; m_h2 = 0; m_cnt = 0; m_fault = 0;
    end else if (iv) begin
      d    = y - 2 * m_h1 - 3 * m_h2;
      m_x  = (d < 0) ? 0 : (d > 15) ? 15 : d;
      m_ov = 1;
      if (!m_fault) begin
        if (d >= 0 && d <= 15) begin
          m_h2  = m_h1;
          m_h1  = d;
          m_cnt = (m_cnt + 1) % 65536;
        end else begin
          m_fault = 1; m_h1 = 0; m_h2 = 0;
        end
      end
    end
  endtask

  initial begin
    int bad_ov;
    // Clean stream, mismatch, fault decoding, recovery, max-value stream, upper boundary.
    tbl.push_back('{0, 1,  1,  1, 1, 0, 1});
    tbl.push_back('{0, 1,  4,  2, 1, 0, 2});
    tbl.push_back('{0, 1, 10,  3, 1, 0, 3});
    tbl.push_back('{0, 1, 16,  4, 1, 0, 4});
    tbl.push_back('{0, 1,  0,  0, 1, 1, 4});
    tbl.push_back('{0, 0,  0,  0, 0, 1, 4});
    tbl.push_back('{0, 1, 20, 15, 1, 1, 4});
    tbl.push_back('{1, 1,  5, 15, 0, 0, 0});
    tbl.push_back('{0, 1,  5,  5, 1, 0, 1});
    tbl.push_back('{1, 0,  0,  5, 0, 0, 0});
    tbl.push_back('{0, 1, 15, 15, 1, 0, 1});
    tbl.push_back('{0, 1, 45, 15, 1, 0, 2});
    tbl.push_back('{0, 1, 90, 15, 1, 0, 3});
    tbl.push_back('{0, 1, 90, 15, 1, 0, 4});
    tbl.push_back('{1, 0,  0, 15, 0, 0, 0});
    tbl.push_back('{0, 1, 16, 15, 1, 1, 0});
    tbl.push_back('{0, 0,  0, 15, 0, 1, 0});
    tbl.push_back('{1, 0,  0, 15, 0, 0, 0});

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_all("reset", 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].sclr, tbl[i].iv, tbl[i].y);
      $display("vec %0d: sclr=%0d iv=%0d y=%0d -> x=%0d ov=%0d err=%0d cnt=%0d",
               i, tbl[i].sclr, tbl[i].iv, tbl[i].y, x_out, out_valid, err, sample_cnt);
      check_all($sformatf("vec%0d", i), tbl[i].ex, tbl[i].eov, tbl[i].eerr, tbl[i].ecnt);
    end

    // Async reset mid-stream, then first sample after it.
    step(0, 1, 3);
    in_valid = 1'b1; y_in = 8'd9;
    #2 rst = 1'b1;
    #1;
    $display("async reset: x=%0d ov=%0d err=%0d cnt=%0d", x_out, out_valid, err, sample_cnt);
    check_all("async_rst", 0, 0, 0, 0);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    step(0, 1, 7);
    $display("post reset: y=7 -> x=%0d ov=%0d cnt=%0d", x_out, out_valid, sample_cnt);
    check_all("post_rst", 7, 1, 0, 1);

    // Randomized run against the reference model.
    pulse_reset();
    model_reset();
    for (int n = 0; n < 2000; n++) begin
      bit sclr, iv;
      int y;
      sclr = ($urandom_range(0, 31) == 0);
      iv   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0)
        y = $urandom_range(0, 255);
      else
        y = $urandom_range(0, 15) + 2 * m_h1 + 3 * m_h2;
      step(sclr, iv, y);
      model_step(sclr, iv, y);
      $display("rnd %0d: sclr=%0d iv=%0d y=%0d -> x=%0d ov=%0d err=%0d cnt=%0d",
               n, sclr, iv, y, x_out, out_valid, err, sample_cnt);
      if (m_ov)
        check($sformatf("rnd%0d x_out", n), 32'(x_out), 32'(m_x));
      check($sformatf("rnd%0d out_valid", n), 32'(out_valid), 32'(m_ov));
      check($sformatf("rnd%0d err", n), 32'(err), 32'(m_fault));
      check($sformatf("rnd%0d sample_cnt", n), 32'(sample_cnt), 32'(m_cnt));
    end

    // Counter wrap with 65536 good zero samples.
    pulse_reset();
    bad_ov = 0;
    for (int n = 0; n < 65535; n++) begin
      step(0, 1, 0);
      if (out_valid !== 1'b1) bad_ov++;
    end
    $display("wrap: 65535 samples, cnt=%0d", sample_cnt);
    check("wrap cnt_max", 32'(sample_cnt), 32'd65535);
    step(0, 1, 0);
    if (out_valid !== 1'b1) bad_ov++;
    $display("wrap: 65536 samples, cnt=%0d ov=%0d", sample_cnt, out_valid);
    check("wrap cnt_zero", 32'(sample_cnt), 32'd0);
    check("wrap missing out_valid", 32'(bad_ov), 32'd0);
    check("wrap err", 32'(err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
